stw_test_controller: RTL and testbench
======================================

# stw_test_controller

Initiator side of the per-PE self-test word (STW) protocol. Sweeps a row of NUM_PE systolic MAC PEs one at a time, in the background. For each PE it broadcasts an LFSR-generated test vector and golden expected value, issues a one-hot start, and waits for the PE's complete/result handshake. Results accumulate in a sticky per-PE fault map that the BISR repair logic consumes. It sits beside the systolic array, and its STW buses fan out to every PE in the row.

## Interface
Parameters:
- WORD_SIZE, 16, operand/result width; supported range 8..16.
- NUM_PE, 16, number of PEs served; PE index width is clog2(NUM_PE).
- TIMEOUT, 8, maximum cycles from start to a valid result before the PE is declared faulty.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- test_en  in  1  when 1, sweeps repeat; when 0, the controller idles after finishing the current PE.
- interval  in  16  idle cycles between sweeps; sampled when a sweep ends.
- clear_faults  in  1  synchronous clear of fault_map.
- stw_test_load_en  out  1  broadcast load strobe for operands and expected value.
- stw_mult_op1, stw_mult_op2, stw_add_op, stw_expected  out  WORD_SIZE  broadcast test vector.
- stw_start  out  NUM_PE  one-hot start, one cycle wide.
- stw_complete  in  NUM_PE  per-PE complete; 1 = idle/done.
- stw_result  in  NUM_PE  per-PE pass (1) / fail (0); valid while complete is 1 after a run.
- fault_map  out  NUM_PE  sticky; bit i = 1 means PE i failed or timed out.
- any_fault  out  1  OR-reduction of fault_map.
- sweep_done  out  1  one-cycle pulse after the last PE of a sweep is checked.
- busy  out  1  1 in every state except IDLE and WAIT_INTERVAL.

## Operation
- Vector source: 16-bit Fibonacci LFSR, reset seed 0xACE1.
  - Feedback bit fb = l[15]^l[13]^l[12]^l[10]; update is l <= {l[14:0], fb}.
  - The LFSR advances once per PE test, in NEXT.
- Vector mapping (all fields truncated to WORD_SIZE LSBs):
  - op1 = l.
  - op2 = ~l.
  - add = l ^ {l[7:0], l[15:8]}.
  - expected = (op1*op2 + add) mod 2^WORD_SIZE, computed from the registered LFSR value.
- Vector outputs hold stable from LOAD through WAIT_HIGH.
- FSM states: IDLE, LOAD, START, WAIT_LOW, WAIT_HIGH, NEXT, WAIT_INTERVAL.
  - IDLE: idx = 0. Go to LOAD when test_en = 1.
  - LOAD: stw_test_load_en = 1 for one cycle; go to START.
  - START: stw_start[idx] = 1 for one cycle; timeout counter cleared; go to WAIT_LOW.
  - WAIT_LOW: on stw_complete[idx] = 0, go to WAIT_HIGH.
  - WAIT_HIGH: on stw_complete[idx] = 1, set fault_map[idx] to ~stw_result[idx] OR its current value; go to NEXT.
  - Timeout: counter runs in WAIT_LOW and WAIT_HIGH. When it reaches TIMEOUT, set fault_map[idx] = 1 and go to NEXT.
  - NEXT: advance LFSR; idx++.
    - If idx was NUM_PE-1: idx wraps to 0, sweep_done pulses, and interval is loaded into the down-counter. Go to WAIT_INTERVAL if test_en = 1, else IDLE.
    - Otherwise: go to LOAD if test_en = 1, else IDLE (idx resets to 0).
  - WAIT_INTERVAL: when the counter is 0, go to LOAD (test_en = 1) or IDLE. interval = 0 gives back-to-back sweeps.
- A PE test in progress (LOAD..WAIT_HIGH) is never abandoned when test_en falls, because the PE's input registers are frozen while its STW runs.
- fault_map bits are set only by the controller; they never clear except by clear_faults or rst. When clear_faults and a fault set hit the same cycle, the set wins for that bit.

## Timing
- Reset values: all outputs 0; LFSR = 0xACE1; state IDLE; idx = 0.
- Conforming PE: start is sampled at edge E; complete drops after E; complete returns to 1 with the result valid after E+1.
- Per-PE test takes 5 cycles: LOAD, START, WAIT_LOW, WAIT_HIGH, NEXT.
- Full sweep with test_en held high: 5*NUM_PE cycles, from leaving IDLE to the sweep_done pulse.
- fault_map updates on the edge that leaves WAIT_HIGH. sweep_done is asserted during the NEXT cycle of PE NUM_PE-1.
- Sweep to sweep: the next LOAD begins interval+1 cycles after NEXT.
- rst asserted mid-test: immediate return to IDLE with outputs cleared. The PE is reset by the same rst.

## Test plan
- After reset with test_en = 1, first LOAD cycle: op1 = 0xACE1, op2 = 0x531E, add = 0x4D4D, expected = 0x82AB, stw_test_load_en = 1. Next cycle stw_start = 0x0001.
- NUM_PE = 4, all PE models pass: sweep_done pulses 20 cycles after leaving IDLE; fault_map = 0x0; busy falls in WAIT_INTERVAL.
- PE 2 model returns result = 0: fault_map = 0x4 and any_fault = 1 after its WAIT_HIGH. A second sweep with PE 2 now passing leaves fault_map at 0x4.
- PE 1 model holds complete = 1 forever: fault_map[1] sets exactly TIMEOUT cycles after START, and the sweep continues with PE 2.
- test_en dropped during WAIT_LOW of PE 1: PE 1 completes and is checked; next state is IDLE; no stw_start to PE 2; re-enable restarts at PE 0.
- interval = 3: exactly 3 WAIT_INTERVAL cycles between the sweep_done pulse and the next LOAD. clear_faults asserted in the same cycle as a fault set on PE 0: bit 0 remains 1 and all other bits clear.

Source files
------------

// File: rtl/stw_test_controller_if.sv
// ----------------------------------------------------------------------------
// stw_test_controller_if
//
// Self-test word (STW) bus between the test controller and a row of systolic
// MAC PEs. The controller broadcasts one test vector plus its golden value to
// every PE, then starts exactly one PE and waits for that PE's handshake.
//
// Handshake: stw_test_load_en is a one-cycle strobe and the vector is stable
// from that cycle until the addressed PE has answered. stw_start is one-hot
// and one cycle wide. The PE drops stw_complete[i] after sampling its start
// bit. It raises it again with stw_result[i] valid (1 = pass). complete = 1
// means idle/done. No back-pressure exists; the controller bounds the wait
// with a timeout instead.
//
// Signals:
//   stw_test_load_en  controller -> PEs  vector load strobe
//   stw_mult_op1/op2  controller -> PEs  multiplier operands
//   stw_add_op        controller -> PEs  accumulator operand
//   stw_expected      controller -> PEs  golden op1*op2+add
//   stw_start         controller -> PEs  one-hot start
//   stw_complete      PEs -> controller  per-PE idle/done
//   stw_result        PEs -> controller  per-PE pass flag
// ----------------------------------------------------------------------------
interface stw_test_controller_if #(
    parameter int WORD_SIZE = 16,
    parameter int NUM_PE    = 16
);
    logic                  stw_test_load_en;
    logic [WORD_SIZE-1:0]  stw_mult_op1;
    logic [WORD_SIZE-1:0]  stw_mult_op2;
    logic [WORD_SIZE-1:0]  stw_add_op;
    logic [WORD_SIZE-1:0]  stw_expected;
    logic [NUM_PE-1:0]     stw_start;
    logic [NUM_PE-1:0]     stw_complete;
    logic [NUM_PE-1:0]     stw_result;

    // Test controller side
    modport master (
        output stw_test_load_en,
        output stw_mult_op1,
        output stw_mult_op2,
        output stw_add_op,
        output stw_expected,
        output stw_start,
        input  stw_complete,
        input  stw_result
    );

    // PE row side
    modport slave (
        input  stw_test_load_en,
        input  stw_mult_op1,
        input  stw_mult_op2,
        input  stw_add_op,
        input  stw_expected,
        input  stw_start,
        output stw_complete,
        output stw_result
    );
endinterface

// File: rtl/stw_test_controller.sv
// ----------------------------------------------------------------------------
// stw_test_controller
//
// Background self-test initiator for one row of NUM_PE systolic MAC PEs.
// The controller tests the PEs one at a time. For each PE it broadcasts an
// LFSR-derived vector and its golden value, then pulses that PE's start bit.
// It then waits for the PE to drop and raise stw_complete. Failures and
// timeouts are collected in a sticky fault map that the repair logic reads.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   test_en       keep sweeping while 1; when it falls, the PE under test is
//                 finished first and then the controller idles
//   interval      idle cycles between sweeps, sampled at the end of a sweep
//   clear_faults  synchronous clear of fault_map (a same-cycle set wins)
//   stw           STW bus, master side
//   fault_map     sticky per-PE fault bits
//   any_fault     OR of fault_map
//   sweep_done    one-cycle pulse in the NEXT cycle of the last PE
//   busy          1 outside IDLE and WAIT_INTERVAL
//   dbg_state_o   current FSM state, for observation only
// ----------------------------------------------------------------------------
module stw_test_controller #(
    parameter int WORD_SIZE = 16,
    parameter int NUM_PE    = 16,
    parameter int TIMEOUT   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   test_en,
    input  logic [15:0]            interval,
    input  logic                   clear_faults,
    stw_test_controller_if.master  stw,
    output logic [NUM_PE-1:0]      fault_map,
    output logic                   any_fault,
    output logic                   sweep_done,
    output logic                   busy,
    output logic [2:0]             dbg_state_o
);

    localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [15:0]      LFSR_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        S_IDLE          = 3'd0,
        S_LOAD          = 3'd1,
        S_START         = 3'd2,
        S_WAIT_LOW      = 3'd3,
        S_WAIT_HIGH     = 3'd4,
        S_NEXT          = 3'd5,
        S_WAIT_INTERVAL = 3'd6
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [15:0]         ivl_q, ivl_d;
    logic [NUM_PE-1:0]   fault_q, fault_d;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic                lfsr_fb;
    logic                cur_complete;
    logic                cur_result;
    logic                tmo_hit;
    logic [NUM_PE-1:0]   fault_set;
    logic [NUM_PE-1:0]   start_vec;
    logic                load_en;
    logic                vec_en;
    logic                sweep_done_c;
    logic                busy_c;

    // Test vector, all derived from the registered LFSR value so that it
    // only changes when the LFSR steps in NEXT.
    logic [WORD_SIZE-1:0] op1_w;
    logic [WORD_SIZE-1:0] op2_w;
    logic [WORD_SIZE-1:0] add_w;
    logic [WORD_SIZE-1:0] exp_w;
    logic [15:0]          add_full;

    assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign add_full = lfsr_q ^ {lfsr_q[7:0], lfsr_q[15:8]};

    assign op1_w = lfsr_q[WORD_SIZE-1:0];
    assign op2_w = ~lfsr_q[WORD_SIZE-1:0];
    assign add_w = add_full[WORD_SIZE-1:0];
    // Product and sum wrap at WORD_SIZE bits, matching the PE datapath.
    assign exp_w = op1_w * op2_w + add_w;

    assign cur_complete = stw.stw_complete[idx_q];
    assign cur_result   = stw.stw_result[idx_q];

    // The counter is cleared in START and counts wait cycles. This is the
    // TIMEOUT-th wait cycle, so the PE is given up on at the edge that ends it.
    assign tmo_hit = (tmo_q == TMO_LAST);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        lfsr_d       = lfsr_q;
        tmo_d        = tmo_q;
        ivl_d        = ivl_q;
        fault_set    = '0;
        start_vec    = '0;
        load_en      = 1'b0;
        vec_en       = 1'b0;
        sweep_done_c = 1'b0;
        busy_c       = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                busy_c = 1'b0;
                idx_d  = '0;
                if (test_en) begin
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                load_en = 1'b1;
                vec_en  = 1'b1;
                state_d = S_START;
            end

            S_START: begin
                vec_en           = 1'b1;
                start_vec[idx_q] = 1'b1;
                tmo_d            = '0;
                state_d          = S_WAIT_LOW;
            end

            S_WAIT_LOW: begin
                vec_en = 1'b1;
                tmo_d  = tmo_q + TMO_W'(1);
                if (!cur_complete) begin
                    state_d = S_WAIT_HIGH;
                end else if (tmo_hit) begin
                    fault_set[idx_q] = 1'b1;
                    state_d          = S_NEXT;
                end
            end

            S_WAIT_HIGH: begin
                vec_en = 1'b1;
                tmo_d  = tmo_q + TMO_W'(1);
                // A handshake that lands on the last allowed cycle is still
                // taken as a real answer rather than a timeout.
                if (cur_complete) begin
                    fault_set[idx_q] = ~cur_result;
                    state_d          = S_NEXT;
                end else if (tmo_hit) begin
                    fault_set[idx_q] = 1'b1;
                    state_d          = S_NEXT;
                end
            end

            S_NEXT: begin
                lfsr_d = {lfsr_q[14:0], lfsr_fb};
                if (idx_q == LAST_IDX) begin
                    idx_d        = '0;
                    sweep_done_c = 1'b1;
                    // WAIT_INTERVAL lasts exactly 'interval' cycles. Zero
                    // skips it, so sweeps run back to back.
                    ivl_d        = interval - 16'd1;
                    if (!test_en) begin
                        state_d = S_IDLE;
                    end else if (interval == 16'd0) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_WAIT_INTERVAL;
                    end
                end else if (test_en) begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_LOAD;
                end else begin
                    idx_d   = '0;
                    state_d = S_IDLE;
                end
            end

            S_WAIT_INTERVAL: begin
                busy_c = 1'b0;
                if (ivl_q == 16'd0) begin
                    state_d = test_en ? S_LOAD : S_IDLE;
                end else begin
                    ivl_d = ivl_q - 16'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase

        // A fault recorded in the same cycle as a clear survives it.
        fault_d = (clear_faults ? '0 : fault_q) | fault_set;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            tmo_q   <= '0;
            ivl_q   <= '0;
            fault_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lfsr_q  <= lfsr_d;
            tmo_q   <= tmo_d;
            ivl_q   <= ivl_d;
            fault_q <= fault_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The vector is driven only while a PE test is in flight. It is zero
    // otherwise, so the bus is quiet in IDLE and after reset.
    assign stw.stw_test_load_en = load_en;
    assign stw.stw_mult_op1     = vec_en ? op1_w : '0;
    assign stw.stw_mult_op2     = vec_en ? op2_w : '0;
    assign stw.stw_add_op       = vec_en ? add_w : '0;
    assign stw.stw_expected     = vec_en ? exp_w : '0;
    assign stw.stw_start        = start_vec;

    assign fault_map   = fault_q;
    assign any_fault   = |fault_q;
    assign sweep_done  = sweep_done_c;
    assign busy        = busy_c;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_stw_test_controller.sv
// ----------------------------------------------------------------------------
// tb_stw_test_controller
//
// Bench for stw_test_controller with NUM_PE = 4. It contains a row of
// behavioural PE models whose pass/fail/hang behaviour can be programmed.
// A monitor checks every broadcast vector against an LFSR reference. It
// also checks every start against the PE that should be next.
// ----------------------------------------------------------------------------
module tb_stw_test_controller;

    localparam int WS  = 16;
    localparam int NPE = 4;
    localparam int TMO = 8;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    logic test_en;
    logic [15:0] interval;
    logic clear_faults;
    logic [NPE-1:0] fault_map;
    logic any_fault;
    logic sweep_done;
    logic busy;
    logic [2:0] dbg_state;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    stw_test_controller_if #(.WORD_SIZE(WS), .NUM_PE(NPE)) stw_bus ();

    stw_test_controller #(.WORD_SIZE(WS), .NUM_PE(NPE), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .test_en      (test_en),
        .interval     (interval),
        .clear_faults (clear_faults),
        .stw          (stw_bus),
        .fault_map    (fault_map),
        .any_fault    (any_fault),
        .sweep_done   (sweep_done),
        .busy         (busy),
        .dbg_state_o  (dbg_state)
    );

    // ---------------- PE row model ----------------
    logic [NPE-1:0] pe_fail;
    logic [NPE-1:0] pe_hang;
    logic [NPE-1:0] pe_phase;
    logic [NPE-1:0] pe_pass;

    function automatic logic [15:0] mac16(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] c);
        logic [31:0] full;
        full = a * b + c;
        return full[15:0];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stw_bus.stw_complete <= '1;
            stw_bus.stw_result   <= '1;
            pe_phase             <= '0;
            pe_pass              <= '1;
        end else begin
            for (int i = 0; i < NPE; i++) begin
                if (pe_phase[i]) begin
                    stw_bus.stw_complete[i] <= 1'b1;
                    stw_bus.stw_result[i]   <= pe_pass[i];
                    pe_phase[i]             <= 1'b0;
                end else if (stw_bus.stw_start[i] && !pe_hang[i]) begin
                    stw_bus.stw_complete[i] <= 1'b0;
                    pe_phase[i]             <= 1'b1;
                    pe_pass[i] <= !pe_fail[i] &&
                        (mac16(stw_bus.stw_mult_op1, stw_bus.stw_mult_op2,
                               stw_bus.stw_add_op) == stw_bus.stw_expected);
                end
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [63:0] vec_of(input logic [15:0] l);
        logic [15:0] o1, o2, ad;
        o1 = l;
        o2 = ~l;
        ad = l ^ {l[7:0], l[15:8]};
        return {o1, o2, ad, mac16(o1, o2, ad)};
    endfunction

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    logic [NPE-1:0] exp_q[$];

    function automatic logic [63:0] bus_vec();
        return {stw_bus.stw_mult_op1, stw_bus.stw_mult_op2,
                stw_bus.stw_add_op, stw_bus.stw_expected};
    endfunction

    // The monitor pushes the expected PE at each load and checks it at the
    // following start. The PE after an idle stretch is always PE 0.
    initial begin : monitor
        logic [15:0] m_lfsr;
        logic [63:0] last_vec;
        int          exp_pe;
        m_lfsr   = 16'hACE1;
        last_vec = '0;
        exp_pe   = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_lfsr = 16'hACE1;
                exp_pe = 0;
                exp_q.delete();
            end else begin
                if (!busy) exp_pe = 0;
                if (stw_bus.stw_test_load_en) begin
                    last_vec = vec_of(m_lfsr);
                    chk("load_vector", bus_vec(), last_vec);
                    m_lfsr = lfsr_next(m_lfsr);
                    exp_q.push_back(NPE'(1 << exp_pe));
                    exp_pe = (exp_pe + 1) % NPE;
                end
                if (stw_bus.stw_start != '0) begin
                    if (exp_q.size() == 0) begin
                        chk("start_unexpected", 64'(stw_bus.stw_start), 64'd0);
                    end else begin
                        chk("start_onehot", 64'(stw_bus.stw_start), 64'(exp_q.pop_front()));
                    end
                    chk("vector_hold", bus_vec(), last_vec);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
    endtask

    // Waits for an event, sampling once per cycle: 0 load, 1 sweep_done,
    // 2 not busy, 3 start == tgt, 4 any start. n is the number of cycles
    // stepped.
    task automatic wait_for(input int which, input logic [NPE-1:0] tgt,
                            input int max_cyc, output int n);
        bit hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < max_cyc) begin
            step();
            n++;
            case (which)
                0: hit = stw_bus.stw_test_load_en;
                1: hit = sweep_done;
                2: hit = !busy;
                3: hit = (stw_bus.stw_start == tgt);
                default: hit = (stw_bus.stw_start != '0);
            endcase
        end
        if (!hit) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_%0d: no event within %0d cycles (target 0x%0h)", which, max_cyc, tgt);
        end
    endtask

    task automatic finish_idle();
        int n;
        test_en = 1'b0;
        wait_for(2, '0, 60, n);
        repeat (8) step();
    endtask

    task automatic clear_pulse();
        clear_faults = 1'b1;
        step();
        clear_faults = 1'b0;
        chk("clear_faults", 64'(fault_map), 64'd0);
    endtask

    // Counts cycles after a sweep_done sample until the next LOAD.
    task automatic measure_gap(input logic [15:0] ivl, input string tag);
        int k, low;
        k   = 0;
        low = 0;
        step();
        while (!stw_bus.stw_test_load_en && k < 40) begin
            k++;
            if (!busy) low++;
            step();
        end
        chk({tag, "_gap"}, 64'(k), 64'(ivl));
        chk({tag, "_busy_low"}, 64'(low), 64'(ivl));
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        logic [NPE-1:0] fail;
        logic [NPE-1:0] hang;
        logic [15:0]    ivl;
        int             len;
        logic [NPE-1:0] fault;
    } row_t;

    row_t rows[6];

    initial begin : main
        int n, k;
        logic [NPE-1:0] exp_acc, f, h;
        logic [15:0] ivl;

        rows[0] = '{fail: 4'b0000, hang: 4'b0000, ivl: 16'd2, len: 20, fault: 4'b0000};
        rows[1] = '{fail: 4'b0100, hang: 4'b0000, ivl: 16'd0, len: 20, fault: 4'b0100};
        rows[2] = '{fail: 4'b0000, hang: 4'b0010, ivl: 16'd1, len: 26, fault: 4'b0010};
        rows[3] = '{fail: 4'b0001, hang: 4'b1000, ivl: 16'd3, len: 26, fault: 4'b1001};
        rows[4] = '{fail: 4'b1111, hang: 4'b0000, ivl: 16'd5, len: 20, fault: 4'b1111};
        rows[5] = '{fail: 4'b0000, hang: 4'b1111, ivl: 16'd0, len: 44, fault: 4'b1111};

        rst = 1'b1;
        test_en = 1'b0;
        interval = 16'd0;
        clear_faults = 1'b0;
        pe_fail = '0;
        pe_hang = '0;

        // Reset state
        repeat (3) step();
        chk("reset_outputs",
            {stw_bus.stw_test_load_en, stw_bus.stw_start, fault_map, any_fault, sweep_done, busy},
            '0);
        chk("reset_vector", bus_vec(), 64'd0);
        rst = 1'b0;
        step();
        chk("idle_busy", 64'(busy), 64'd0);

        // First LOAD after reset: fixed golden values
        interval = 16'd2;
        test_en  = 1'b1;
        wait_for(0, '0, 5, n);
        chk("first_load_delay", 64'(n), 64'd1);
        chk("first_op1", 64'(stw_bus.stw_mult_op1), 64'hACE1);
        chk("first_op2", 64'(stw_bus.stw_mult_op2), 64'h531E);
        chk("first_add", 64'(stw_bus.stw_add_op), 64'h4D4D);
        chk("first_expected", 64'(stw_bus.stw_expected), 64'h82AB);
        step();
        chk("first_start", 64'(stw_bus.stw_start), 64'h1);
        chk("load_one_cycle", 64'(stw_bus.stw_test_load_en), 64'd0);
        wait_for(1, '0, 100, n);
        chk("first_sweep_len", 64'(n + 2), 64'd20);
        chk("first_fault_map", 64'(fault_map), 64'd0);
        step();
        chk("sweep_done_pulse", 64'(sweep_done), 64'd0);
        chk("busy_in_interval", 64'(busy), 64'd0);
        finish_idle();

        // Table-driven sweeps
        foreach (rows[r]) begin
            clear_pulse();
            pe_fail  = rows[r].fail;
            pe_hang  = rows[r].hang;
            interval = rows[r].ivl;
            test_en  = 1'b1;
            wait_for(0, '0, 5, n);
            chk($sformatf("row%0d_idle_to_load", r), 64'(n), 64'd1);
            wait_for(1, '0, 200, n);
            chk($sformatf("row%0d_sweep_len", r), 64'(n + 1), 64'(rows[r].len));
            chk($sformatf("row%0d_fault_map", r), 64'(fault_map), 64'(rows[r].fault));
            chk($sformatf("row%0d_any_fault", r), 64'(any_fault), 64'(|rows[r].fault));
            measure_gap(rows[r].ivl, $sformatf("row%0d", r));
            finish_idle();
        end
        pe_fail = '0;
        pe_hang = '0;

        // PE 2 fails, then passes on the next sweep: fault stays sticky
        clear_pulse();
        pe_fail  = 4'b0100;
        interval = 16'd0;
        test_en  = 1'b1;
        wait_for(3, 4'b0100, 40, n);
        step();
        step();
        chk("pe2_fault_not_early", 64'(fault_map), 64'd0);
        step();
        chk("pe2_fault_set", 64'(fault_map), 64'h4);
        chk("pe2_any_fault", 64'(any_fault), 64'd1);
        pe_fail = '0;
        wait_for(1, '0, 40, n);
        chk("pe2_sweep1_map", 64'(fault_map), 64'h4);
        wait_for(1, '0, 40, n);
        chk("pe2_sticky", 64'(fault_map), 64'h4);
        finish_idle();

        // PE 1 never answers: timeout, then the sweep moves on to PE 2
        clear_pulse();
        pe_hang = 4'b0010;
        test_en = 1'b1;
        wait_for(3, 4'b0010, 40, n);
        k = 0;
        do begin
            step();
            k++;
        end while (!fault_map[1] && k < 30);
        // start sampled at the edge after the START sample; fault set TMO edges later
        chk("timeout_latency", 64'(k), 64'(TMO + 1));
        chk("timeout_map", 64'(fault_map), 64'h2);
        wait_for(4, '0, 10, n);
        chk("timeout_continue_pe2", 64'(stw_bus.stw_start), 64'h4);
        pe_hang = '0;
        finish_idle();

        // test_en drops during WAIT_LOW of PE 1
        clear_pulse();
        pe_fail = 4'b0010;
        test_en = 1'b1;
        wait_for(3, 4'b0010, 40, n);
        step();
        test_en = 1'b0;
        step();
        step();
        chk("drop_pe1_checked", 64'(fault_map), 64'h2);
        chk("drop_busy_next", 64'(busy), 64'd1);
        step();
        chk("drop_idle", 64'(busy), 64'd0);
        k = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (stw_bus.stw_start != '0 || stw_bus.stw_test_load_en) k++;
        end
        chk("drop_no_activity", 64'(k), 64'd0);
        pe_fail = '0;
        test_en = 1'b1;
        wait_for(4, '0, 10, n);
        chk("drop_restart_pe0", 64'(stw_bus.stw_start), 64'h1);
        finish_idle();

        // interval = 3, then clear_faults colliding with a PE 0 fault
        clear_pulse();
        pe_fail  = 4'b1110;
        interval = 16'd3;
        test_en  = 1'b1;
        wait_for(1, '0, 40, n);
        chk("ivl3_map", 64'(fault_map), 64'hE);
        measure_gap(16'd3, "ivl3");
        pe_fail = 4'b0001;
        step();
        step();
        step();
        chk("pre_clear_map", 64'(fault_map), 64'hE);
        clear_faults = 1'b1;
        step();
        clear_faults = 1'b0;
        chk("clear_vs_set", 64'(fault_map), 64'h1);
        wait_for(1, '0, 40, n);
        chk("after_clear_sweep", 64'(fault_map), 64'h1);

        // Asynchronous reset in the middle of a PE test
        wait_for(4, '0, 20, n);
        step();
        #2 rst = 1'b1;
        #1;
        chk("async_reset_outputs",
            {stw_bus.stw_test_load_en, stw_bus.stw_start, fault_map, any_fault, sweep_done, busy},
            '0);
        chk("async_reset_vector", bus_vec(), 64'd0);
        test_en = 1'b0;
        pe_fail = '0;
        step();
        step();
        #2 rst = 1'b0;
        step();
        test_en = 1'b1;
        step();
        chk("reseed_after_reset", {stw_bus.stw_test_load_en, stw_bus.stw_mult_op1}, {1'b1, 16'hACE1});
        finish_idle();

        // Randomised back-to-back sweeps against the accumulated fault model
        clear_pulse();
        exp_acc = '0;
        test_en = 1'b1;
        wait_for(0, '0, 5, n);
        for (int it = 0; it < 12; it++) begin
            f   = NPE'($urandom_range(0, 15));
            h   = ($urandom_range(0, 3) == 0) ? NPE'(1 << $urandom_range(0, NPE - 1)) : '0;
            ivl = 16'($urandom_range(0, 4));
            pe_fail  = f;
            pe_hang  = h;
            interval = ivl;
            wait_for(1, '0, 200, n);
            chk($sformatf("rand%0d_sweep_len", it), 64'(n + 1),
                64'(5 * NPE + (TMO - 2) * $countones(h)));
            exp_acc = exp_acc | f | h;
            chk($sformatf("rand%0d_fault_map", it), 64'(fault_map), 64'(exp_acc));
            measure_gap(ivl, $sformatf("rand%0d", it));
        end
        pe_fail = '0;
        pe_hang = '0;
        finish_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
